// File: rtl/inv_sub_word_seq_pkg.sv
// Shared types for the sequential inverse SubWord engine.
package inv_sub_word_seq_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = 2;

  typedef logic [BYTE_W-1:0] t_opaque_AESByte;
  typedef t_opaque_AESByte [WORD_BYTES-1:0] t_opaque_AESWord;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } t_inv_sw_state;

endpackage

// File: rtl/inv_sub_word_seq_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_sbox
  import inv_sub_word_seq_pkg::*;
(
  input  t_opaque_AESByte lhs,
  output t_opaque_AESByte o
);

  localparam t_opaque_AESByte INV_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Table lookup indexed by the input byte
  assign o = INV_TBL[lhs];

endmodule

// File: rtl/inv_sub_word_seq.sv
// Sequential inverse SubWord: one byte per cycle through a shared inverse S-box.
// Optional macro AES_INV_ROTWORD_EN applies InvRotWord wiring at the output.
module inv_sub_word_seq
  import inv_sub_word_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  t_opaque_AESWord in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output t_opaque_AESWord out_word
);

  t_inv_sw_state    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  t_opaque_AESWord  cap_q, cap_d;
  t_opaque_AESWord  res_q, res_d;
  t_opaque_AESByte  sbox_in, sbox_out;
  logic             accept;

  // Handshake decode; DONE frees the slot in the same cycle the result leaves
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign sbox_in   = cap_q[idx_q];

  inv_sbox u_inv_sbox (
    .lhs (sbox_in),
    .o   (sbox_out)
  );

  // Next-state: capture on accept, substitute one byte per SUB cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          cap_d   = in_word;
          idx_d   = '0;
          state_d = SUB;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SUB: begin
        res_d[idx_q] = sbox_out;
        if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
    end
  end

`ifdef AES_INV_ROTWORD_EN
  // InvRotWord: out_word[i] = result[(i+3) mod 4]
  assign out_word = {res_q[2], res_q[1], res_q[0], res_q[3]};
`else
  assign out_word = res_q;
`endif

endmodule

// File: tb/tb_inv_sub_word_seq.sv
// Scoreboard bench for inv_sub_word_seq; reference S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_word_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  inv_sub_word_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word)
  );

`ifdef AES_INV_ROTWORD_EN
  localparam logic [31:0] T1_EXP = 32'h02010003;
  localparam logic [31:0] T2_EXP = 32'h53FF5248;
`else
  localparam logic [31:0] T1_EXP = 32'h03020100;
  localparam logic [31:0] T2_EXP = 32'h4853FF52;
`endif

  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  logic [7:0]  fwd_tbl [256];
  logic [7:0]  inv_tbl [256];
  logic [31:0] exp_q [$];
  logic [31:0] in_q [$];
  int          acc_q [$];
  int          last_rise = 0;
  int          prev_rise = 0;
  int          coincide_cnt = 0;
  int          xfer_cnt = 0;
  logic [31:0] last_out = '0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pw = '0;
  bit          rand_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no matching event, expected one (cycle %0d)", name, cycle);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  // Forward S-box = affine(GF inverse); inverse table obtained by inversion of that map
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      b = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      fwd_tbl[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
  endtask

  function automatic logic [31:0] permute(input logic [31:0] w);
`ifdef AES_INV_ROTWORD_EN
    return {w[23:16], w[15:8], w[7:0], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = inv_tbl[w[8*i +: 8]];
    return permute(r);
  endfunction

  function automatic logic [31:0] fwd_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = fwd_tbl[w[8*i +: 8]];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Monitor: latency, hold stability, output scoreboard, and accept recording
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (acc_q.size() == 0) flag("valid_without_accept");
        else check("latency", 32'(cycle - acc_q.pop_front()), 32'd4);
        prev_rise = last_rise;
        last_rise = cycle;
      end
      if (out_valid && pv && !pr) check("hold_word", out_word, pw);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag("unexpected_transfer");
        else begin
          logic [31:0] e, iw;
          e  = exp_q.pop_front();
          iw = in_q.pop_front();
          check("out_word", out_word, e);
          check("preimage", fwd_word(out_word), permute(iw));
        end
        last_out = out_word;
        xfer_cnt++;
        if (in_valid && in_ready) coincide_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_word));
        in_q.push_back(in_word);
        acc_q.push_back(cycle + 1);
      end
      pv = out_valid;
      pr = out_ready;
      pw = out_word;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_word  = w;
    forever begin
      @(negedge clk); #1;
      if (in_ready) break;
      t++;
      if (t > 200) begin
        flag("send_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    forever begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) break;
      t++;
      if (t > 300) begin
        flag("drain_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    forever begin
      @(negedge clk); #1;
      if (out_valid) break;
      t++;
      if (t > 20) begin
        flag("valid_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int c0;
    logic [31:0] w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_word", out_word, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vectors
    out_ready = 1'b1;
    send(32'h7B777C63);
    drain();
    check("t1_vector", last_out, T1_EXP);
    send(32'h52ED1600);
    drain();
    check("t2_edge_bytes", last_out, T2_EXP);

    // Backpressure: result held, no accept, exactly one transfer on release
    out_ready = 1'b0;
    send($urandom);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_word  = $urandom;
      @(negedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    n0        = xfer_cnt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("bp_one_xfer", 32'(xfer_cnt - n0), 32'd1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    drain();

    // Back-to-back
    out_ready = 1'b1;
    c0 = coincide_cnt;
    send($urandom);
    send($urandom);
    drain();
    check("b2b_coincide", 32'(coincide_cnt - c0), 32'd1);
    check("b2b_spacing", 32'(last_rise - prev_rise), 32'd5);

    // Asynchronous reset in the middle of SUB
    send($urandom);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_word", out_word, 32'd0);
    exp_q.delete();
    in_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h7B777C63);
    drain();
    check("post_rst_vector", last_out, T1_EXP);

    // All byte values in rotating positions
    for (int k = 0; k < 64; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w[8*((j + k) % 4) +: 8] = 8'(4*k + j);
      send(w);
    end
    drain();

    // Random words with random downstream stalls
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send($urandom);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
